shift_rows_pipe: RTL and testbench
==================================

// Module: shift_rows_pipe
// PURPOSE
//  Registered, handshaked Rijndael ShiftRows / InvShiftRows engine.
//  Mode is selected per transaction. Supports block widths Nb = 4, 6 or 8.
//  Has a 1- or 2-stage elastic pipeline and sits between SubBytes and MixColumns in the round datapath.
//  State layout: bit 0 = MSB. Byte k = bits [8k:8k+7] is row k%4, column k/4.
// PARAMETERS
//  NB      4  columns in the state (legal: 4, 6, 8); state width W = 32*NB
//  IN_REG  1  1 = input register stage (latency 2); 0 = none (latency 1)
// PORTS
//  clk        in   1  single clock; every register updates on its rising edge
//  rst_n      in   1  reset, synchronous, active-low
//  inValid    in   1  inState/inMode hold a transaction
//  inReady    out  1  engine accepts the transaction this cycle
//  inMode     in   1  0 = forward ShiftRows, 1 = InvShiftRows
//  inState    in   W  [0:W-1] state to permute
//  outValid   out  1  outState holds a result
//  outReady   in   1  downstream accepts the result this cycle
//  outState   out  W  [0:W-1] permuted state
//  outMode    out  1  mode that produced outState (tag for the round controller)
// BEHAVIOUR
//  Row offsets: s(r) = {0,1,2,3} for NB=4,6; {0,1,3,4} for NB=8.
//  Forward: out[r][c] = in[r][(c+s(r)) mod NB].
//  Inverse: out[r][c] = in[r][(c-s(r)+NB) mod NB].
//  Row 0 is never moved. No arithmetic beyond the mod-NB column index, which is resolved at elaboration.
//  Transfer rules:
//   - Input transfer occurs when inValid & inReady.
//   - Output transfer occurs when outValid & outReady.
//   - Each stage is a valid-flagged register. A stage loads when it is empty or its contents leave in the same cycle.
//   - inReady = !v_last | outReady, propagated backward through stages.
//   - Combinational path exists only on the ready chain. No combinational path from inState to outState.
//  Latency: accept->outValid is 1 cycle (IN_REG=0) or 2 cycles (IN_REG=1).
//  Throughput: 1 transaction per cycle with outReady held high.
//  Bubbles collapse: an empty downstream stage is filled even while outReady=0.
//  Stall: while outValid & !outReady, outState/outMode/outValid are held stable.
//  Simultaneous accept and emit in one cycle: both occur with no loss and no duplication.
//  inMode is captured with its data and travels with it. A mode change between back-to-back transactions is legal.
//  Reset (rst_n=0 at clk edge):
//   - All valid flags clear; outValid=0.
//   - outState = 0 and outMode = 0; data registers also clear (deterministic for sim).
//   - inReady = 1 from the first cycle after reset deasserts.
//  Reset mid-operation: in-flight transactions are discarded, never emitted.
//  During reset inReady = 0.
//  Illegal NB: elaboration-time $error. No runtime checks.
// STRUCTURE
//  aes_pkg:
//   - BYTE_W = 8
//   - function shift_off(nb, row) returning s(r)
//   - typedef mode_e {SR_FWD=0, SR_INV=1}
//  Sub-module shift_rows_perm #(NB):
//   - purely combinational; mode, in -> out
//   - generate-loop byte mux, one 2:1 mux per byte
//  Top: IN_REG stage, perm, output stage, ready chain.
// TESTING
//  - NB=4, fwd, in=000102..0f, outReady=1
//     -> 2 cycles later out=00050a0f 04090e03 080d0207 0c01060b
//  - NB=4, inv, same in
//     -> out=000d0a07 04010e0b 08050 20f 0c090603 (no spaces: 08050 20f = 0805020f)
//  - NB=8, fwd, in=00..1f -> out[0:31]=0005 0e13; round trip fwd then inv returns input for 1000 random states
//  - outReady=0 for 5 cycles with inValid=1
//     -> exactly 2 (IN_REG=1) entries accepted, inReady=0
//     -> outState stable, order preserved on release
//  - alternating mode each cycle at full rate -> outMode tags match; zero bubbles
//  - rst_n=0 for one cycle with 2 in flight -> outValid=0 next cycle; nothing emitted; inReady=1 after

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared types, constants and helpers for the Rijndael
//                ShiftRows datapath (byte width, row count, row offsets,
//                transaction mode tag).
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Width of one state byte.
  localparam int BYTE_W = 8;

  // A Rijndael state always has four rows.
  localparam int ROWS = 4;

  // Direction of the row rotation carried with each transaction.
  typedef enum logic {
    SR_FWD = 1'b0,
    SR_INV = 1'b1
  } mode_e;

  // Row rotation amount s(r). Wide blocks (Nb=8) use the larger offsets
  // {0,1,3,4}; Nb=4 and Nb=6 use {0,1,2,3}. Evaluated only at elaboration.
  function automatic int shift_off(input int nb, input int row);
    int off;
    off = row;
    if (row == 0) begin
      off = 0;
    end else if (nb == 8 && row >= 2) begin
      off = row + 1;
    end
    return off;
  endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/shift_rows_perm.sv
`default_nettype none
// ============================================================================
//  Module      : shift_rows_perm
//  Description : Purely combinational ShiftRows / InvShiftRows byte
//                permutation. Every output byte is a 2:1 mux between the
//                forward-source and inverse-source byte of the same row;
//                all column indices are fixed at elaboration.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  mode_e                  mode_i,
  input  logic [0:ROWS*BYTE_W*NB-1] state_i,
  output logic [0:ROWS*BYTE_W*NB-1] state_o
);

  // Byte k of the state sits at row k%4, column k/4, bits [8k : 8k+7].
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam int SHIFT   = shift_off(NB, r);
      localparam int FWD_COL = (c + SHIFT) % NB;
      localparam int INV_COL = (c - SHIFT + NB) % NB;
      localparam int DST     = BYTE_W * (ROWS * c + r);
      localparam int FWD_SRC = BYTE_W * (ROWS * FWD_COL + r);
      localparam int INV_SRC = BYTE_W * (ROWS * INV_COL + r);

      assign state_o[DST +: BYTE_W] = (mode_i == SR_INV) ? state_i[INV_SRC +: BYTE_W]
                                                         : state_i[FWD_SRC +: BYTE_W];
    end
  end

endmodule : shift_rows_perm
`default_nettype wire

// File: rtl/shift_rows_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : shift_rows_pipe
//  Description : Registered, valid/ready handshaked ShiftRows/InvShiftRows
//                engine. Optional input register stage, combinational byte
//                permutation, then an output register stage. Each stage is a
//                valid-flagged register that loads when empty or draining;
//                the ready chain is the only combinational path back.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int IN_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic             inMode,
  input  logic [0:32*NB-1] inState,
  output logic             outValid,
  input  logic             outReady,
  output logic [0:32*NB-1] outState,
  output logic             outMode
);

  localparam int W = 32 * NB;

  // Reject unsupported configurations before any hardware is built.
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8 (got %0d)", NB);
  end
  if (!(IN_REG == 0 || IN_REG == 1)) begin : g_bad_in_reg
    $error("shift_rows_pipe: IN_REG must be 0 or 1 (got %0d)", IN_REG);
  end

  // Transaction presented to the permutation / output stage.
  logic         feed_valid_w;
  logic [0:W-1] feed_state_w;
  mode_e        feed_mode_w;
  logic [0:W-1] perm_state_w;

  // Output stage registers.
  logic         out_valid_q, out_valid_d;
  logic [0:W-1] out_state_q, out_state_d;
  mode_e        out_mode_q,  out_mode_d;
  logic         out_ready_w;

  // Output stage can take new data when empty or its result leaves now.
  assign out_ready_w = !out_valid_q || outReady;

  if (IN_REG != 0) begin : g_in_reg
    logic         in_valid_q, in_valid_d;
    logic [0:W-1] in_state_q, in_state_d;
    mode_e        in_mode_q,  in_mode_d;
    logic         stage_ready_w;

    assign stage_ready_w = !in_valid_q || out_ready_w;

    // Input stage next state: reload from the port whenever this stage frees up.
    always_comb begin
      in_valid_d = in_valid_q;
      in_state_d = in_state_q;
      in_mode_d  = in_mode_q;
      if (stage_ready_w) begin
        in_valid_d = inValid;
        if (inValid) begin
          in_state_d = inState;
          in_mode_d  = mode_e'(inMode);
        end
      end
    end

    // Input stage registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        in_valid_q <= 1'b0;
        in_state_q <= '0;
        in_mode_q  <= SR_FWD;
      end else begin
        in_valid_q <= in_valid_d;
        in_state_q <= in_state_d;
        in_mode_q  <= in_mode_d;
      end
    end

    // Ready is forced low while reset is asserted.
    assign inReady      = rst_n && stage_ready_w;
    assign feed_valid_w = in_valid_q;
    assign feed_state_w = in_state_q;
    assign feed_mode_w  = in_mode_q;
  end else begin : g_no_in_reg
    assign inReady      = rst_n && out_ready_w;
    assign feed_valid_w = inValid;
    assign feed_state_w = inState;
    assign feed_mode_w  = mode_e'(inMode);
  end

  shift_rows_perm #(
    .NB(NB)
  ) u_perm (
    .mode_i (feed_mode_w),
    .state_i(feed_state_w),
    .state_o(perm_state_w)
  );

  // Output stage next state: hold while stalled, otherwise take the permuted feed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_state_d = out_state_q;
    out_mode_d  = out_mode_q;
    if (out_ready_w) begin
      out_valid_d = feed_valid_w;
      if (feed_valid_w) begin
        out_state_d = perm_state_w;
        out_mode_d  = feed_mode_w;
      end
    end
  end

  // Output stage registers; cleared to a deterministic all-zero state on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      out_mode_q  <= SR_FWD;
    end else begin
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
      out_mode_q  <= out_mode_d;
    end
  end

  assign outValid = out_valid_q;
  assign outState = out_state_q;
  assign outMode  = out_mode_q;

endmodule : shift_rows_pipe
`default_nettype wire

// File: tb/tb_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_rows_pipe
//  Description : Self-checking bench for shift_rows_pipe. An NB=4 two-stage
//                instance is checked through an expected-result queue and an
//                independent output monitor; an NB=8 single-stage instance is
//                checked for the reference vector and fwd/inv round trips.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst_n;

  // NB=4, IN_REG=1 instance
  logic         a_in_valid, a_in_ready, a_in_mode;
  logic [0:127] a_in_state;
  logic         a_out_valid, a_out_ready, a_out_mode;
  logic [0:127] a_out_state;

  // NB=8, IN_REG=0 instance
  logic         b_in_valid, b_in_ready, b_in_mode;
  logic [0:255] b_in_state;
  logic         b_out_valid, b_out_ready, b_out_mode;
  logic [0:255] b_out_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int emit_cnt = 0;

  typedef struct {
    logic         mode;
    logic [0:127] st;
  } exp_t;

  exp_t exp_q[$];
  int   emit_cyc_q[$];

  localparam logic [0:127] IN4  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] FWD4 = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [0:127] INV4 = 128'h000d0a0704010e0b0805020f0c090603;

  shift_rows_pipe #(.NB(4), .IN_REG(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .inValid(a_in_valid), .inReady(a_in_ready), .inMode(a_in_mode), .inState(a_in_state),
    .outValid(a_out_valid), .outReady(a_out_ready), .outState(a_out_state), .outMode(a_out_mode)
  );

  shift_rows_pipe #(.NB(8), .IN_REG(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .inValid(b_in_valid), .inReady(b_in_ready), .inMode(b_in_mode), .inState(b_in_state),
    .outValid(b_out_valid), .outReady(b_out_ready), .outState(b_out_state), .outMode(b_out_mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // NB=4 reference: forward takes column c+r, inverse takes column c-r (mod 4).
  function automatic logic [0:127] ref4(input logic [0:127] s, input logic inv);
    logic [0:127] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] rand128();
    logic [0:127] o;
    for (int i = 0; i < 4; i++) o[32*i +: 32] = $urandom;
    return o;
  endfunction

  function automatic logic [0:255] rand256();
    logic [0:255] o;
    for (int i = 0; i < 8; i++) o[32*i +: 32] = $urandom;
    return o;
  endfunction

  // Output monitor: every transfer on DUT A is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && a_out_valid && a_out_ready) begin
      emit_cnt++;
      emit_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got state %h mode %b, required no output", a_out_state, a_out_mode);
      end else begin
        e = exp_q.pop_front();
        if (a_out_state !== e.st || a_out_mode !== e.mode) begin
          errors++;
          $display("FAIL sb_out: got state %h mode %b, required state %h mode %b",
                   a_out_state, a_out_mode, e.st, e.mode);
        end
      end
    end
  end

  // Present one transaction on DUT A; starts and ends just after a rising edge.
  task automatic send_a(input logic [0:127] st, input logic m, input logic [0:127] ex);
    exp_t e;
    bit ok;
    a_in_valid = 1'b1;
    a_in_state = st;
    a_in_mode  = m;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (a_in_ready) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got inReady=0 for 50 cycles, required 1");
    end else begin
      e.mode = m;
      e.st   = ex;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [0:127] tx[4];
    logic [0:127] snap, st;
    logic [0:255] orig, mid;
    bit           have;
    int           acc, idx, n0;

    rst_n = 1'b0;
    a_in_valid = 0; a_in_mode = 0; a_in_state = '0; a_out_ready = 1'b1;
    b_in_valid = 0; b_in_mode = 0; b_in_state = '0; b_out_ready = 1'b1;

    // ---- reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inReady_low", 256'(a_in_ready), 256'(1'b0));
    chk("rst_outValid", 256'(a_out_valid), 256'(1'b0));
    chk("rst_outState", 256'(a_out_state), 256'(0));
    chk("rst_outMode", 256'(a_out_mode), 256'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_inReady", 256'(a_in_ready), 256'(1'b1));
    @(posedge clk); #1;

    // ---- forward vector with latency check
    send_a(IN4, 1'b0, FWD4);
    @(negedge clk);
    chk("lat_not_early", 256'(a_out_valid), 256'(1'b0));
    @(negedge clk);
    chk("lat_two_cycles", 256'(a_out_valid), 256'(1'b1));
    drain_a();

    // ---- inverse vector
    send_a(IN4, 1'b1, INV4);
    drain_a();

    // ---- alternating modes at full rate, no bubbles
    emit_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      st = rand128();
      send_a(st, i[0], ref4(st, i[0]));
    end
    drain_a();
    chk("burst_count", 256'(emit_cyc_q.size()), 256'(8));
    if (emit_cyc_q.size() == 8)
      chk("burst_no_bubbles", 256'(emit_cyc_q[7] - emit_cyc_q[0]), 256'(7));

    // ---- stall: outReady low for 5 cycles with inValid held
    for (int i = 0; i < 4; i++) tx[i] = rand128();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_mode   = 1'b0;
    idx = 0; acc = 0; have = 0; snap = '0;
    a_in_state = tx[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (a_in_ready) begin
        exp_q.push_back('{mode: 1'b0, st: ref4(tx[idx], 1'b0)});
        acc++;
        idx++;
      end
      if (a_out_valid) begin
        if (!have) begin snap = a_out_state; have = 1; end
        else chk("stall_stable", 256'(a_out_state), 256'(snap));
      end
      @(posedge clk); #1;
      a_in_state = tx[idx];
    end
    a_in_valid = 1'b0;
    chk("stall_accepted", 256'(acc), 256'(2));
    @(negedge clk);
    chk("stall_inReady_low", 256'(a_in_ready), 256'(1'b0));
    chk("stall_outValid", 256'(a_out_valid), 256'(1'b1));
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    drain_a();

    // ---- reset with two transactions in flight
    a_out_ready = 1'b0;
    send_a(IN4, 1'b0, FWD4);
    send_a(IN4, 1'b1, INV4);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_inReady_low", 256'(a_in_ready), 256'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_outValid", 256'(a_out_valid), 256'(1'b0));
    chk("midrst_inReady", 256'(a_in_ready), 256'(1'b1));
    n0 = emit_cnt;
    repeat (4) @(negedge clk);
    chk("midrst_no_emit", 256'(emit_cnt - n0), 256'(0));
    @(posedge clk); #1;

    // ---- NB=8 reference vector
    for (int i = 0; i < 32; i++) b_in_state[8*i +: 8] = 8'(i);
    b_in_mode  = 1'b0;
    b_in_valid = 1'b1;
    @(negedge clk);
    chk("nb8_inReady", 256'(b_in_ready), 256'(1'b1));
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("nb8_outValid", 256'(b_out_valid), 256'(1'b1));
    chk("nb8_fwd_word0", 256'(b_out_state[0:31]), 256'(32'h00050e13));
    chk("nb8_fwd_mode", 256'(b_out_mode), 256'(1'b0));
    @(posedge clk); #1;

    // ---- NB=8 forward then inverse returns the input
    for (int i = 0; i < 1000; i++) begin
      orig = rand256();
      b_in_state = orig; b_in_mode = 1'b0; b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      @(negedge clk);
      mid = b_out_state;
      b_in_state = mid; b_in_mode = 1'b1; b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      @(negedge clk);
      if (i == 0) chk("nb8_inv_mode", 256'(b_out_mode), 256'(1'b1));
      chk("nb8_roundtrip", b_out_state, orig);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_shift_rows_pipe
`default_nettype wire
